// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control path: FSM states, opcodes,
// immediate formats, datapath mux selects and ALU operations.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_UPPER    = 4'd11,
        S_ILLEGAL  = 4'd12
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'd0,
        ALUOP_SUB   = 2'd1,
        ALUOP_FUNCT = 2'd2
    } alu_op_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_NONE = 3'b000;
    localparam logic [2:0] IMM_R    = 3'b001;
    localparam logic [2:0] IMM_I    = 3'b010;
    localparam logic [2:0] IMM_S    = 3'b011;
    localparam logic [2:0] IMM_B    = 3'b100;
    localparam logic [2:0] IMM_U    = 3'b101;
    localparam logic [2:0] IMM_J    = 3'b110;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    function automatic logic [2:0] imm_sel(input logic [6:0] op);
        logic [2:0] sel;
        case (op)
            OP_RTYPE:                   sel = IMM_R;
            OP_LOAD, OP_ITYPE, OP_JALR: sel = IMM_I;
            OP_STORE:                   sel = IMM_S;
            OP_BRANCH:                  sel = IMM_B;
            OP_LUI, OP_AUIPC:           sel = IMM_U;
            OP_JAL:                     sel = IMM_J;
            default:                    sel = IMM_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// ALU operation decode: fixed add/sub for address and compare steps, funct3/funct7
// decode for R- and I-type arithmetic, plus a flag for unsupported funct3 values.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control,
    output logic       funct_illegal
);

    logic [2:0] funct_ctrl;

    // funct_illegal depends on funct3 only, so the FSM can read it without a
    // combinational path back through alu_op.
    always_comb begin
        funct_ctrl    = ALU_ADD;
        funct_illegal = 1'b0;
        case (funct3)
            3'b000:  funct_ctrl = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b010:  funct_ctrl = ALU_SLT;
            3'b110:  funct_ctrl = ALU_OR;
            3'b111:  funct_ctrl = ALU_AND;
            default: funct_illegal = 1'b1;
        endcase
    end

    always_comb begin
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: alu_control = funct_ctrl;
            default:     alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main Moore control FSM of the multicycle RV32I core: sequences fetch, decode,
// execute, memory and writeback, and drives all datapath enables and selects.
module multicycle_control
    import riscv_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic [2:0] alu_control,
    output logic [2:0] imm_control,
    output logic       illegal
);

    state_t  state, state_n;
    alu_op_t alu_op;
    logic    funct_illegal;
    logic    ir_write_c, pc_write_c, reg_write_c;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_FETCH;
        else       state <= state_n;
    end

    always_comb begin
        case (state)
            S_EXECUTER, S_EXECUTEI: alu_op = ALUOP_FUNCT;
            S_BRANCH:               alu_op = ALUOP_SUB;
            default:                alu_op = ALUOP_ADD;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op       (alu_op),
        .funct3       (funct3),
        .funct7b5     (funct7b5),
        .op5          (opcode[5]),
        .alu_control  (alu_control),
        .funct_illegal(funct_illegal)
    );

    always_comb begin
        state_n     = state;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write_c  = 1'b0;
        pc_write_c  = 1'b0;
        reg_write_c = 1'b0;
        alu_src_a   = SRCA_PC;
        alu_src_b   = SRCB_RS2;
        result_src  = RES_ALUOUT;
        illegal     = 1'b0;
        case (state)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = SRCB_FOUR;
                result_src = RES_ALU;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
                if (mem_ready) state_n = S_DECODE;
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_n = S_MEMADR;
                    OP_RTYPE:          state_n = S_EXECUTER;
                    OP_ITYPE:          state_n = S_EXECUTEI;
                    OP_BRANCH:         state_n = S_BRANCH;
                    OP_JAL:            state_n = S_JAL;
                    OP_LUI, OP_AUIPC:  state_n = S_UPPER;
                    default:           state_n = S_ILLEGAL;
                endcase
            end
            S_MEMADR: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                // Loads and stores differ only in opcode bit 5.
                state_n   = opcode[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_n = S_MEMWB;
            end
            S_MEMWB: begin
                result_src  = RES_RDATA;
                reg_write_c = 1'b1;
                state_n     = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_n = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_RS2;
                state_n   = funct_illegal ? S_ILLEGAL : S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a = SRCA_RS1;
                alu_src_b = SRCB_IMM;
                state_n   = funct_illegal ? S_ILLEGAL : S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                state_n     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_RS2;
                // funct3[0] inverts the sense: beq takes on zero, bne on non-zero.
                pc_write_c = zero ^ funct3[0];
                state_n    = S_FETCH;
            end
            S_JAL: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                pc_write_c = 1'b1;
                state_n    = S_ALUWB;
            end
            S_UPPER: begin
                alu_src_a = opcode[5] ? SRCA_ZERO : SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                state_n   = S_ALUWB;
            end
            S_ILLEGAL: begin
                illegal = 1'b1;
            end
            default: state_n = S_FETCH;
        endcase
    end

    // Architectural write enables are masked while reset is held.
    assign ir_write    = ir_write_c & ~reset;
    assign pc_write    = pc_write_c & ~reset;
    assign reg_write   = reg_write_c & ~reset;
    assign imm_control = imm_sel(opcode);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: the driver queues the expected output
// vector of every cycle, a negedge monitor pops and compares it.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] alu_control, imm_control;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .reg_write  (reg_write),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_control(alu_control),
        .imm_control(imm_control),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [18:0] e;
        logic [18:0] m;
        string       nm;
    } chk_t;

    chk_t        q[$];
    chk_t        cur;
    int          n_checks = 0;
    int          n_pass = 0;
    logic [18:0] obs;
    localparam logic [18:0] ALL = '1;
    localparam logic [18:0] NO_ALU = ~19'h00070;

    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, alu_control, imm_control, illegal};

    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            n_checks++;
            if (((obs ^ cur.e) & cur.m) == '0) n_pass++;
            else $display("FAIL %s: got %h expected %h (mask %h)", cur.nm, obs, cur.e, cur.m);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish, %0d checks queued", q.size());
        $fatal(1, "timeout");
    end

    // Pending instruction fields and the hand-derived imm_control for them.
    logic [6:0] i_op;
    logic [2:0] i_f3;
    logic       i_f7;
    logic [2:0] ei;

    task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                             input logic [2:0] imm);
        i_op = op; i_f3 = f3; i_f7 = f7; ei = imm;
    endtask

    function automatic logic [18:0] ov(input logic mreq, mw, as, irw, pcw, rw,
                                       input logic [1:0] a, b, rs, input logic [2:0] alu,
                                       input logic ill);
        return {mreq, mw, as, irw, pcw, rw, a, b, rs, alu, ei, ill};
    endfunction

    function automatic logic [18:0] e_fetch(input logic rdy);
        return ov(1, 0, 0, rdy, rdy, 0, 2'b00, 2'b10, 2'b10, 3'b000, 0);
    endfunction
    function automatic logic [18:0] e_dec();  return ov(0,0,0,0,0,0, 2'b01,2'b01,2'b00, 3'b000, 0); endfunction
    function automatic logic [18:0] e_madr(); return ov(0,0,0,0,0,0, 2'b10,2'b01,2'b00, 3'b000, 0); endfunction
    function automatic logic [18:0] e_mrd();  return ov(1,0,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 0); endfunction
    function automatic logic [18:0] e_mwb();  return ov(0,0,0,0,0,1, 2'b00,2'b00,2'b01, 3'b000, 0); endfunction
    function automatic logic [18:0] e_mwr();  return ov(1,1,1,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 0); endfunction
    function automatic logic [18:0] e_awb();  return ov(0,0,0,0,0,1, 2'b00,2'b00,2'b00, 3'b000, 0); endfunction
    function automatic logic [18:0] e_jal();  return ov(0,0,0,0,1,0, 2'b01,2'b10,2'b00, 3'b000, 0); endfunction
    function automatic logic [18:0] e_ill();  return ov(0,0,0,0,0,0, 2'b00,2'b00,2'b00, 3'b000, 1); endfunction
    function automatic logic [18:0] e_ex(input logic [1:0] b, input logic [2:0] alu);
        return ov(0, 0, 0, 0, 0, 0, 2'b10, b, 2'b00, alu, 0);
    endfunction
    function automatic logic [18:0] e_br(input logic pcw);
        return ov(0, 0, 0, 0, pcw, 0, 2'b10, 2'b00, 2'b00, 3'b001, 0);
    endfunction
    function automatic logic [18:0] e_up(input logic [1:0] a);
        return ov(0, 0, 0, 0, 0, 0, a, 2'b01, 2'b00, 3'b000, 0);
    endfunction

    task automatic step_m(input logic rs_v, input logic rdy, input logic z,
                          input logic [18:0] e, input logic [18:0] m, input string nm);
        chk_t c;
        @(posedge clk);
        #1;
        reset = rs_v; mem_ready = rdy; zero = z;
        opcode = i_op; funct3 = i_f3; funct7b5 = i_f7;
        c.e = e; c.m = m; c.nm = nm;
        q.push_back(c);
    endtask

    task automatic step(input logic rs_v, input logic rdy, input logic z,
                        input logic [18:0] e, input string nm);
        step_m(rs_v, rdy, z, e, ALL, nm);
    endtask

    task automatic run_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                           input logic [2:0] imm, input logic [2:0] alu, input string nm);
        set_instr(op, f3, f7, imm);
        step(0, 1, 0, e_fetch(1), {nm, "_fetch"});
        step(0, 1, 0, e_dec(), {nm, "_decode"});
        step(0, 1, 0, e_ex(op[5] ? 2'b00 : 2'b01, alu), {nm, "_execute"});
        step(0, 1, 0, e_awb(), {nm, "_aluwb"});
    endtask

    task automatic run_br(input logic [2:0] f3, input logic z, input logic pcw, input string nm);
        set_instr(7'b1100011, f3, 0, 3'b100);
        step(0, 1, 0, e_fetch(1), {nm, "_fetch"});
        step(0, 0, z, e_dec(), {nm, "_decode"});
        step(0, 0, z, e_br(pcw), {nm, "_branch"});
    endtask

    task automatic run_up(input logic [6:0] op, input logic [1:0] a, input string nm);
        set_instr(op, 3'b000, 0, 3'b101);
        step(0, 1, 0, e_fetch(1), {nm, "_fetch"});
        step(0, 1, 0, e_dec(), {nm, "_decode"});
        step(0, 1, 0, e_up(a), {nm, "_upper"});
        step(0, 1, 0, e_awb(), {nm, "_aluwb"});
    endtask

    initial begin
        chk_t c;
        reset = 1'b1; mem_ready = 1'b0; zero = 1'b0;
        set_instr(7'h00, 3'b000, 0, 3'b000);
        opcode = 7'h00; funct3 = 3'b000; funct7b5 = 1'b0;

        step(1, 0, 0, e_fetch(0), "reset_fetch");
        step(0, 0, 0, e_fetch(0), "fetch_wait");

        run_alu(7'b0110011, 3'b000, 0, 3'b001, 3'b000, "add");
        run_alu(7'b0110011, 3'b000, 1, 3'b001, 3'b001, "sub");
        run_alu(7'b0010011, 3'b000, 1, 3'b010, 3'b000, "addi");
        run_alu(7'b0010011, 3'b010, 0, 3'b010, 3'b101, "slti");
        run_alu(7'b0010011, 3'b110, 0, 3'b010, 3'b011, "ori");
        run_alu(7'b0110011, 3'b111, 0, 3'b001, 3'b010, "and");

        // lw with two wait cycles in MEMREAD: 7 cycles
        set_instr(7'b0000011, 3'b010, 0, 3'b010);
        step(0, 1, 0, e_fetch(1), "lw_fetch");
        step(0, 1, 0, e_dec(), "lw_decode");
        step(0, 1, 0, e_madr(), "lw_memadr");
        step(0, 0, 0, e_mrd(), "lw_memread_w1");
        step(0, 0, 0, e_mrd(), "lw_memread_w2");
        step(0, 1, 0, e_mrd(), "lw_memread_rdy");
        step(0, 1, 0, e_mwb(), "lw_memwb");

        // sw with one wait cycle in FETCH
        set_instr(7'b0100011, 3'b010, 0, 3'b011);
        step(0, 0, 0, e_fetch(0), "sw_fetch_wait");
        step(0, 1, 0, e_fetch(1), "sw_fetch");
        step(0, 1, 0, e_dec(), "sw_decode");
        step(0, 1, 0, e_madr(), "sw_memadr");
        step(0, 1, 0, e_mwr(), "sw_memwrite");

        run_br(3'b000, 1, 1, "beq_taken");
        run_br(3'b000, 0, 0, "beq_not");
        run_br(3'b001, 1, 0, "bne_not");
        run_br(3'b001, 0, 1, "bne_taken");

        set_instr(7'b1101111, 3'b000, 0, 3'b110);
        step(0, 1, 0, e_fetch(1), "jal_fetch");
        step(0, 1, 0, e_dec(), "jal_decode");
        step(0, 1, 0, e_jal(), "jal_jal");
        step(0, 1, 0, e_awb(), "jal_aluwb");

        run_up(7'b0110111, 2'b11, "lui");
        run_up(7'b0010111, 2'b01, "auipc");

        // asynchronous reset in the middle of a MEMREAD cycle
        set_instr(7'b0000011, 3'b010, 0, 3'b010);
        step(0, 1, 0, e_fetch(1), "rst_lw_fetch");
        step(0, 1, 0, e_dec(), "rst_lw_decode");
        step(0, 1, 0, e_madr(), "rst_lw_memadr");
        step(0, 0, 0, e_mrd(), "rst_lw_memread");
        @(posedge clk);
        #2;
        reset = 1'b1;
        c.e = e_fetch(0); c.m = ALL; c.nm = "async_reset_midcycle";
        q.push_back(c);
        step(0, 0, 0, e_fetch(0), "after_reset_fetch");

        // unsupported opcode: sticky for 100 cycles, cleared by reset
        set_instr(7'h7F, 3'b000, 0, 3'b000);
        step(0, 1, 0, e_fetch(1), "ill_op_fetch");
        step(0, 1, 0, e_dec(), "ill_op_decode");
        for (int i = 0; i < 100; i++) step(0, i[0], i[1], e_ill(), "ill_op_hold");
        step(1, 0, 0, e_fetch(0), "ill_op_reset");
        step(0, 0, 0, e_fetch(0), "ill_op_after_reset");

        // R-type with unsupported funct3
        set_instr(7'b0110011, 3'b001, 0, 3'b001);
        step(0, 1, 0, e_fetch(1), "ill_f3_fetch");
        step(0, 1, 0, e_dec(), "ill_f3_decode");
        step_m(0, 1, 0, e_ex(2'b00, 3'b000), NO_ALU, "ill_f3_execute");
        for (int i = 0; i < 5; i++) step(0, 1, 1, e_ill(), "ill_f3_hold");
        step(1, 0, 0, e_fetch(0), "ill_f3_reset");
        step(0, 0, 0, e_fetch(0), "ill_f3_after_reset");

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_checks++;
            $display("FAIL drain: %0d checks left, required 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RV32I core. It sequences the shared datapath (ALU, instruction/data memory port, register file and immediate decoder) through fetch, decode, execute, memory and writeback steps. It also drives the immediate decoder's `immControl` select from the opcode held in the instruction register. It sits beside the datapath, takes the latched instruction fields and ALU `zero`, and returns all enables and mux selects.

## Interface
- No parameters.
- `clk` in 1: core clock, rising edge.
- `reset` in 1: asynchronous, active-high; forces FETCH.
- `opcode` in 7: instr[6:0] from the instruction register.
- `funct3` in 3: instr[14:12].
- `funct7b5` in 1: instr[30].
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory port completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `mem_write` out 1: access is a store.
- `adr_src` out 1: 0 selects PC, 1 selects ALUOut.
- `ir_write` out 1: latch the fetched instruction and old PC.
- `pc_write` out 1: PC update enable.
- `reg_write` out 1: register file write enable.
- `alu_src_a` out 2: 00 PC, 01 oldPC, 10 rs1, 11 zero.
- `alu_src_b` out 2: 00 rs2, 01 imm, 10 constant 4.
- `result_src` out 2: 00 ALUOut, 01 read data, 10 ALU result.
- `alu_control` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `imm_control` out 3: immediate format select.
- `illegal` out 1: sticky unsupported-opcode flag.

## Operation
- Moore FSM with a 4-bit state and 13 states. Outputs are decoded from the state, except `imm_control`, which is decoded from `opcode`. Any output not listed for a state is 0.
- **FETCH**: `mem_req`, `adr_src`=0, a=00, b=10, op add, `result_src`=10.
  - `ir_write` and `pc_write` equal `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE**: a=01, b=01, op add (branch/JAL target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECUTER
  - 0010011 → EXECUTEI
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 0110111 or 0010111 → UPPER
  - anything else → ILLEGAL
- **MEMADR**: a=10, b=01, add. Load → MEMREAD; store → MEMWRITE.
- **MEMREAD**: `mem_req`, `adr_src`=1. Waits for `mem_ready`, then MEMWB.
- **MEMWB**: `result_src`=01, `reg_write`. Then FETCH.
- **MEMWRITE**: `mem_req`, `mem_write`, `adr_src`=1. Waits for `mem_ready`, then FETCH.
- **EXECUTER**: a=10, b=00, funct-decoded op. Then ALUWB.
- **EXECUTEI**: a=10, b=01, funct-decoded op. Then ALUWB.
- **ALUWB**: `result_src`=00, `reg_write`. Then FETCH.
- **BRANCH**: a=10, b=00, sub, `result_src`=00.
  - `pc_write` = `zero` XOR `funct3[0]` (beq taken on equal, bne taken on not-equal).
  - Then FETCH.
- **JAL**: a=01, b=10, add, `result_src`=00, `pc_write`=1. Then ALUWB, which writes oldPC+4.
- **UPPER**: a=11 for LUI (opcode bit5=1) or 01 for AUIPC, b=01, add. Then ALUWB.
- **ILLEGAL**: `illegal`=1, all enables 0. Absorbing; left only by `reset`.
- **Funct decode** (R/I):
  - funct3 000 → add, or sub when R-type and `funct7b5`=1 (I-type addi always adds).
  - funct3 010 → slt; 110 → or; 111 → and.
  - Other funct3 values → ILLEGAL, taken from EXECUTER/EXECUTEI instead of ALUWB.
- **`imm_control`**:
  - 001 R (0110011)
  - 010 I (0000011, 0010011, 1100111)
  - 011 S (0100011)
  - 100 B (1100011)
  - 101 U (0110111, 0010111)
  - 110 J (1101111)
  - 000 for any other opcode

## Timing
- **Reset**: the state is FETCH immediately. Outputs are FETCH values with `ir_write`=`pc_write`=0 while `mem_ready`=0, `illegal`=0, `reg_write`=0, `mem_write`=0.
- **Reset mid-instruction**: no partial writeback. `reg_write` and `pc_write` drop in the same cycle as reset.
- **Latency with `mem_ready` tied high**:
  - R/I/upper: 4 cycles
  - load: 5 cycles
  - store and branch: 4 and 3 cycles
  - JAL: 4 cycles
- **Memory wait**: each cycle of `mem_ready`=0 in FETCH, MEMREAD or MEMWRITE adds exactly one cycle. Outputs stay stable while waiting.
- **`mem_ready` outside memory states**: ignored.
- **`zero` sampling**: used only combinationally in BRANCH.

## Structure
- **Package `riscv_ctrl_pkg`**:
  - state enum
  - opcode constants
  - `imm_control` codes (shared with the immediate decoder)
  - ALU source, result and `alu_control` codes
- **Sub-module `alu_decoder`**: input `alu_op` (add/sub/funct) plus `funct3`, `funct7b5` and opcode bit5; outputs `alu_control` and a funct-illegal flag.

## Test plan
- **Reset during MEMREAD**, asserted asynchronously mid-cycle → state is FETCH with no clock edge, `reg_write`=0.
- **`add x3,x1,x2` (0x002081B3)**, ready high → DECODE `imm_control`=001, EXECUTER `alu_control`=000, ALUWB `reg_write` in cycle 4, then FETCH.
- **`lw` with `mem_ready` low 2 cycles in MEMREAD** → load takes 7 cycles; `adr_src`=1 held throughout; MEMWB `result_src`=01.
- **`beq` (0x00208463)**: `zero`=1 → `pc_write`=1 in BRANCH; `zero`=0 → `pc_write`=0. `bne` gives the inverse; `imm_control`=100.
- **`jal` (0x008000EF)** → `imm_control`=110; JAL `pc_write`=1; ALUWB writes `result_src`=00.
- **Opcode 0x7F, or R-type funct3=001** → `illegal`=1, held for 100 cycles, no enables; cleared by `reset`.
